// File: rtl/flappy_pkg.sv
// Shared game geometry, physics constants and game-state encoding for the flappy dot.
// The drawer and pipe logic import this package so that every block uses the same field geometry.
package flappy_pkg;

  localparam int Y_W      = 7;
  localparam int V_W      = 5;
  localparam int Y_START  = 60;
  localparam int Y_MAX    = 119;
  localparam int GRAVITY  = 1;
  localparam int FLAP_VEL = -3;
  localparam int V_MAX    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2
  } game_state_e;

endpackage

// File: rtl/rise_edge.sv
// Registered rising-edge detector. The edge output is combinational on the current input,
// so a press is seen in the same cycle that it arrives.
module rise_edge (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic edge_o
);

  logic d_q;

  // Previous-cycle sample of the input.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign edge_o = d_i & ~d_q;

endmodule

// File: rtl/dot_physics.sv
// Vertical motion engine for the flappy dot: gravity, flap impulse, collision detection,
// the IDLE/PLAY/DEAD game state, and the moved strobe that tells the drawer to redraw the dot.
module dot_physics
  import flappy_pkg::*;
(
  input  logic           CLOCK_50,
  input  logic           reset,
  input  logic           tick,
  input  logic           flap,
  input  logic           start,
  output logic [Y_W-1:0] dot_y,
  output logic           moved,
  output logic           alive,
  output logic           game_over
);

  game_state_e            state_q;
  logic [Y_W-1:0]         dot_y_q;
  logic signed [V_W-1:0]  vel_q;
  logic                   pend_q;
  logic                   moved_q;
  logic                   alive_q;
  logic                   game_over_q;

  logic                   flap_edge;
  logic signed [V_W:0]    vel_inc_d;
  logic signed [V_W-1:0]  vel_d;
  logic signed [Y_W+1:0]  ny_d;

  rise_edge u_flap_edge (
    .clk_i   (CLOCK_50),
    .reset_i (reset),
    .d_i     (flap),
    .edge_o  (flap_edge)
  );

  // Next velocity and candidate position; the position is evaluated two bits wider so it cannot wrap.
  always_comb begin
    vel_inc_d = $signed({vel_q[V_W-1], vel_q}) + $signed((V_W+1)'(GRAVITY));
    if (pend_q | flap_edge) begin
      vel_d = $signed(V_W'(FLAP_VEL));
    end else if (vel_inc_d > $signed((V_W+1)'(V_MAX))) begin
      vel_d = $signed(V_W'(V_MAX));
    end else begin
      vel_d = vel_inc_d[V_W-1:0];
    end
    ny_d = $signed({2'b00, dot_y_q}) + $signed({{(Y_W+2-V_W){vel_d[V_W-1]}}, vel_d});
  end

  // Game state machine with registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= IDLE;
      dot_y_q     <= Y_W'(Y_START);
      vel_q       <= '0;
      pend_q      <= 1'b0;
      moved_q     <= 1'b0;
      alive_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          moved_q <= 1'b0;
          if (start) begin
            state_q <= PLAY;
            vel_q   <= '0;
            pend_q  <= 1'b0;
            alive_q <= 1'b1;
          end
        end
        PLAY: begin
          if (tick) begin
            vel_q   <= vel_d;
            pend_q  <= 1'b0;
            moved_q <= 1'b1;
            if (ny_d < $signed((Y_W+2)'(0))) begin
              dot_y_q     <= '0;
              state_q     <= DEAD;
              alive_q     <= 1'b0;
              game_over_q <= 1'b1;
            end else if (ny_d >= $signed((Y_W+2)'(Y_MAX))) begin
              dot_y_q     <= Y_W'(Y_MAX);
              state_q     <= DEAD;
              alive_q     <= 1'b0;
              game_over_q <= 1'b1;
            end else begin
              dot_y_q <= ny_d[Y_W-1:0];
            end
          end else begin
            moved_q <= 1'b0;
            if (flap_edge) begin
              pend_q <= 1'b1;
            end
          end
        end
        DEAD: begin
          if (start) begin
            state_q     <= IDLE;
            dot_y_q     <= Y_W'(Y_START);
            vel_q       <= '0;
            pend_q      <= 1'b0;
            moved_q     <= 1'b1;
            game_over_q <= 1'b0;
          end else begin
            moved_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          moved_q     <= 1'b0;
          alive_q     <= 1'b0;
          game_over_q <= 1'b0;
        end
      endcase
    end
  end

  assign dot_y     = dot_y_q;
  assign moved     = moved_q;
  assign alive     = alive_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_dot_physics.sv
// Scoreboard bench for dot_physics: a behavioural game model predicts each cycle's outputs,
// and a monitor process compares the DUT outputs against the predictions.
module tb_dot_physics;

  logic       CLOCK_50;
  logic       reset;
  logic       tick;
  logic       flap;
  logic       start;
  logic [6:0] dot_y;
  logic       moved;
  logic       alive;
  logic       game_over;

  int n_checks;
  int n_fails;

  typedef struct {
    int y;
    bit moved;
    bit alive;
    bit dead;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state (plain integers; 0 = idle, 1 = play, 2 = dead).
  int m_state;
  int m_y;
  int m_v;
  bit m_fprev;
  bit m_pend;
  bit m_moved;

  dot_physics dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .tick      (tick),
    .flap      (flap),
    .start     (start),
    .dot_y     (dot_y),
    .moved     (moved),
    .alive     (alive),
    .game_over (game_over)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // One clock edge of the game rules.
  task automatic model_step(input bit r, input bit t, input bit f, input bit s);
    bit edge_seen;
    int vn;
    int ny;
    if (r) begin
      m_state = 0; m_y = 60; m_v = 0; m_fprev = 0; m_pend = 0; m_moved = 0;
      return;
    end
    edge_seen = f && !m_fprev;
    m_fprev = f;
    m_moved = 0;
    if (m_state == 0) begin
      if (s) begin m_state = 1; m_v = 0; m_pend = 0; end
    end else if (m_state == 1) begin
      if (t) begin
        if (m_pend || edge_seen) vn = -3;
        else vn = (m_v + 1 > 3) ? 3 : m_v + 1;
        ny = m_y + vn;
        if (ny < 0) begin m_y = 0; m_state = 2; end
        else if (ny >= 119) begin m_y = 119; m_state = 2; end
        else m_y = ny;
        m_v = vn; m_pend = 0; m_moved = 1;
      end else if (edge_seen) begin
        m_pend = 1;
      end
    end else begin
      if (s) begin m_state = 0; m_y = 60; m_v = 0; m_pend = 0; m_moved = 1; end
    end
  endtask

  // Drive one cycle, push the predicted outputs, and return just after the edge.
  task automatic cyc(input bit r, input bit t, input bit f, input bit s);
    exp_t e;
    @(negedge CLOCK_50);
    reset = r; tick = t; flap = f; start = s;
    model_step(r, t, f, s);
    e.y = m_y; e.moved = m_moved; e.alive = (m_state == 1); e.dead = (m_state == 2);
    exp_q.push_back(e);
    @(posedge CLOCK_50);
    #2;
  endtask

  // Monitor: compare the DUT against the oldest prediction after every edge.
  always @(posedge CLOCK_50) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("dot_y", int'(dot_y), e.y);
      check("moved", int'(moved), int'(e.moved));
      check("alive", int'(alive), int'(e.alive));
      check("game_over", int'(game_over), int'(e.dead));
    end
  end

  initial begin
    n_checks = 0;
    n_fails = 0;
    reset = 1'b1; tick = 1'b0; flap = 1'b0; start = 1'b0;

    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("reset_y", int'(dot_y), 60);
    check("reset_alive", int'(alive), 0);
    check("reset_over", int'(game_over), 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 0);
    check("idle_tick_y", int'(dot_y), 60);
    check("idle_tick_moved", int'(moved), 0);

    // Gravity up to terminal velocity.
    cyc(0, 0, 0, 1);
    check("start_alive", int'(alive), 1);
    cyc(0, 1, 0, 0); check("grav1", int'(dot_y), 61); check("grav1_moved", int'(moved), 1);
    cyc(0, 0, 0, 0); check("grav1_moved_off", int'(moved), 0);
    cyc(0, 1, 0, 0); check("grav2", int'(dot_y), 63);
    cyc(0, 1, 0, 0); check("grav3", int'(dot_y), 66);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); check("grav4", int'(dot_y), 69);

    // Held flap gives one impulse.
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0); check("flap1", int'(dot_y), 66);
    cyc(0, 1, 1, 0); check("flap2", int'(dot_y), 64);
    cyc(0, 1, 1, 0); check("flap3", int'(dot_y), 63);
    cyc(0, 0, 0, 0);

    // Fall to the ground: 63,64,66,69 then +3 per tick.
    for (int i = 0; i < 40 && m_state == 1; i++) cyc(0, 1, 0, 0);
    check("ground_y", int'(dot_y), 119);
    check("ground_over", int'(game_over), 1);
    check("ground_alive", int'(alive), 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 0);
    check("dead_hold_y", int'(dot_y), 119);
    cyc(0, 0, 0, 1);
    check("restart_y", int'(dot_y), 60);
    check("restart_moved", int'(moved), 1);
    cyc(0, 0, 0, 0);
    check("restart_moved_off", int'(moved), 0);

    // Flap coincident with tick.
    cyc(0, 0, 0, 1);
    cyc(0, 1, 1, 0); check("coincident_flap", int'(dot_y), 57);
    cyc(0, 0, 0, 0);

    // Reset during a tick in play.
    cyc(1, 1, 1, 0);
    check("midreset_y", int'(dot_y), 60);
    check("midreset_moved", int'(moved), 0);
    check("midreset_alive", int'(alive), 0);

    // Flap to the ceiling.
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 40 && m_state == 1; i++) begin
      cyc(0, 1, 1, 0);
      cyc(0, 0, 0, 0);
    end
    check("ceiling_y", int'(dot_y), 0);
    check("ceiling_over", int'(game_over), 1);

    // Randomized play.
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 3) == 0) ? ~flap : flap, ($urandom_range(0, 24) == 0));
    end

    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
